mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 27 ++
 rtl/mem_loader_pack.sv | 48 ++++
 rtl/mem_loader.sv | 156 +++++++++++++++
 tb/tb_mem_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg -- shared types and helpers for the program-image loader.
//   state_t : loader FSM states
//   be_mask : byte-enable mask covering lanes 0..last_lane
package mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int LANES = 4;

   function automatic logic [LANES-1:0] be_mask(input logic [1:0] last_lane);
      logic [LANES-1:0] m;
      case (last_lane)
         2'd0:    m = 4'b0001;
         2'd1:    m = 4'b0011;
         2'd2:    m = 4'b0111;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_loader_pack.sv
// mem_loader_pack -- byte-to-word lane packer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          restart packing at lane 0 with an empty word
//   acc          a byte is being accepted this cycle
//   flush        accepted byte closes the word early (image end)
//   byte_data    incoming byte
//   lane         lane the next accepted byte lands in
//   word_next    current partial word with byte_data merged at lane
// The stored word is zeroed whenever a word is emitted, so lanes not yet
// filled always read as zero in word_next.
module mem_loader_pack (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        acc,
   input  logic        flush,
   input  logic [7:0]  byte_data,
   output logic [1:0]  lane,
   output logic [31:0] word_next
);

   logic [31:0] word;

   always_comb begin
      word_next = word;
      word_next[{lane, 3'b000} +: 8] = byte_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word <= '0;
         lane <= '0;
      end else if (clr) begin
         word <= '0;
         lane <= '0;
      end else if (acc) begin
         if (lane == 2'd3 || flush) begin
            word <= '0;
            lane <= '0;
         end else begin
            word <= word_next;
            lane <= lane + 2'd1;
         end
      end
   end

endmodule

// File: rtl/mem_loader.sv
// mem_loader -- streams a byte image into 32-bit memory words, then
// releases the core from reset.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start                         pulse: begin a load (IDLE/DONE/ERR only)
//   byte_data/valid/last, ready   byte stream handshake
//   mem_we/addr/wdata/be          word write port (little-endian lanes)
//   busy, done, err_ovf           status (done, err_ovf sticky)
//   core_rst_n                    core reset, released only in DONE
//   word_cnt, chksum              words written, running word sum
// Build option: define MEM_LOADER_CHKSUM_EN to build the checksum adder;
// otherwise chksum is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_LOAD  | accepting bytes, emitting full words
// ST_FLUSH | final (possibly partial) word being written
// ST_DONE  | image loaded, core released
// ST_ERR   | image exceeded capacity, core held in reset
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic              core_rst_n,
   output logic [ADDR_W:0]   word_cnt,
   output logic [31:0]       chksum
);

   state_t            state;
   logic              start_ok;
   logic              accept;
   logic              overflow;
   logic              pack_acc;
   logic [1:0]        lane;
   logic [31:0]       word_next;
   logic [ADDR_W+1:0] cnt_eff;

   assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign accept   = byte_valid && byte_ready;
   // A write in flight has not yet bumped word_cnt; count it so a byte
   // arriving in that same cycle is still judged against true capacity.
   assign cnt_eff  = {1'b0, word_cnt} + (ADDR_W+2)'(mem_we);
   assign overflow = cnt_eff >= (ADDR_W+2)'(MAX_WORDS);
   assign pack_acc = accept && !overflow;

   mem_loader_pack u_pack (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (start_ok),
      .acc       (pack_acc),
      .flush     (byte_last),
      .byte_data (byte_data),
      .lane      (lane),
      .word_next (word_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         mem_we     <= 1'b0;
         mem_addr   <= ADDR_W'(BASE_ADDR);
         mem_wdata  <= '0;
         mem_be     <= '0;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_ovf    <= 1'b0;
         core_rst_n <= 1'b0;
         word_cnt   <= '0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we) begin
            mem_addr <= mem_addr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
         end
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state      <= ST_LOAD;
                  mem_addr   <= ADDR_W'(BASE_ADDR);
                  word_cnt   <= '0;
                  done       <= 1'b0;
                  err_ovf    <= 1'b0;
                  busy       <= 1'b1;
                  byte_ready <= 1'b1;
                  core_rst_n <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  if (overflow) begin
                     state      <= ST_ERR;
                     err_ovf    <= 1'b1;
                     byte_ready <= 1'b0;
                     busy       <= 1'b0;
                  end else begin
                     if (lane == 2'd3 || byte_last) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= word_next;
                        mem_be    <= be_mask(lane);
                     end
                     if (byte_last) begin
                        state      <= ST_FLUSH;
                        byte_ready <= 1'b0;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               state      <= ST_DONE;
               done       <= 1'b1;
               busy       <= 1'b0;
               core_rst_n <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
               core_rst_n <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_LOADER_CHKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chksum <= '0;
      else if (start_ok)
         chksum <= '0;
      else if (mem_we)
         chksum <= chksum + mem_wdata;
   end
`else
   assign chksum = '0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader -- self-checking bench for mem_loader. Two instances share
// the byte stream: dut0 with default capacity, dut1 with MAX_WORDS=2.
// Expected writes, counts and checksums come from a byte-list model.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;

   logic        ready0, we0, busy0, done0, err0, crst0;
   logic [11:0] addr0;
   logic [31:0] wdata0, cs0;
   logic [3:0]  be0;
   logic [12:0] wc0;

   logic        ready1, we1, busy1, done1, err1, crst1;
   logic [11:0] addr1;
   logic [31:0] wdata1, cs1;
   logic [3:0]  be1;
   logic [12:0] wc1;

   mem_loader dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(ready0),
      .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_be(be0),
      .busy(busy0), .done(done0), .err_ovf(err0), .core_rst_n(crst0),
      .word_cnt(wc0), .chksum(cs0)
   );

   mem_loader #(.MAX_WORDS(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(ready1),
      .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_be(be1),
      .busy(busy1), .done(done1), .err_ovf(err1), .core_rst_n(crst1),
      .word_cnt(wc1), .chksum(cs1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   wr_t        wq0[$];
   wr_t        wq1[$];
   logic [7:0] img[$];
   int         total = 0;
   int         bad = 0;

   always @(negedge clk) begin
      if (we0) wq0.push_back(wr_t'{addr0, wdata0, be0});
      if (we1) wq1.push_back(wr_t'{addr1, wdata1, be1});
   end

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
      bit ok = 1'b0;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      byte_last  = last;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = (ready0 === 1'b1);
         @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_byte accepted=0 required=1");
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_img(input int maxgap, input int start_at, input bit use_last);
      for (int i = 0; i < img.size(); i++) begin
         if (i == start_at) start = 1'b1;
         send_byte(img[i], use_last && (i == img.size() - 1),
                   (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
         start = 1'b0;
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic check_image(input string name, input int which);
      wr_t         q[$];
      int          n, maxw, nw;
      bit          ovf;
      logic [31:0] d, sum;
      logic [3:0]  be;
      logic [12:0] wc;
      logic [31:0] cs;
      logic        eo;
      n    = img.size();
      maxw = (which == 1) ? 2 : 4096;
      ovf  = n > 4 * maxw;
      nw   = ovf ? maxw : (n + 3) / 4;
      if (which == 1) begin q = wq1; wc = wc1; cs = cs1; eo = err1; end
      else            begin q = wq0; wc = wc0; cs = cs0; eo = err0; end
      total++;
      if (q.size() != nw) begin
         bad++;
         $display("FAIL %s nwrites got=%0d exp=%0d", name, q.size(), nw);
      end
      sum = '0;
      for (int w = 0; w < nw && w < q.size(); w++) begin
         d  = '0;
         be = '0;
         for (int k = 0; k < 4; k++)
            if (4 * w + k < n) begin
               d[8*k +: 8] = img[4*w + k];
               be[k] = 1'b1;
            end
         sum += d;
         total++;
         if (q[w] !== wr_t'{12'(w), d, be}) begin
            bad++;
            $display("FAIL %s write%0d got=%h/%h/%h exp=%h/%h/%h", name, w,
                     q[w].addr, q[w].data, q[w].be, 12'(w), d, be);
         end
      end
`ifndef MEM_LOADER_CHKSUM_EN
      sum = '0;
`endif
      total++;
      if (wc !== 13'(nw)) begin
         bad++;
         $display("FAIL %s word_cnt got=%0d exp=%0d", name, wc, nw);
      end
      total++;
      if (cs !== sum) begin
         bad++;
         $display("FAIL %s chksum got=%h exp=%h", name, cs, sum);
      end
      total++;
      if (eo !== ovf) begin
         bad++;
         $display("FAIL %s err_ovf got=%b exp=%b", name, eo, ovf);
      end
   endtask

   // Called one cycle after the last byte was accepted.
   task automatic finish_load(input string name);
      total++;
      if ({we0, done0, busy0, crst0} !== 4'b1010) begin
         bad++;
         $display("FAIL %s flush we/done/busy/crst got=%b exp=1010", name,
                  {we0, done0, busy0, crst0});
      end
      @(negedge clk);
      total++;
      if ({we0, done0, busy0, crst0, ready0} !== 5'b01010) begin
         bad++;
         $display("FAIL %s done we/done/busy/crst/ready got=%b exp=01010", name,
                  {we0, done0, busy0, crst0, ready0});
      end
      check_image(name, 0);
   endtask

   task automatic check_reset_vals(input string name);
      total++;
      if ({we0, ready0, busy0, done0, err0, crst0} !== 6'b0 ||
          addr0 !== 12'd0 || wdata0 !== 32'd0 || be0 !== 4'd0 ||
          wc0 !== 13'd0 || cs0 !== 32'd0) begin
         bad++;
         $display("FAIL %s reset ctl=%b addr=%h wdata=%h be=%h wc=%0d cs=%h exp all zero",
                  name, {we0, ready0, busy0, done0, err0, crst0}, addr0, wdata0,
                  be0, wc0, cs0);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("in_reset");
      rst_n = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      repeat (2) @(negedge clk);
      byte_valid = 1'b0;
      check_reset_vals("idle_after_reset");
   endtask

   task automatic test_seq8();
      img.delete();
      for (int i = 1; i <= 8; i++) img.push_back(8'(i));
      wq0.delete(); wq1.delete();
      do_start();
      send_img(0, -1, 1'b1);
      finish_load("seq8");
      check_image("seq8_cap2", 1);
      total++;
      if (done1 !== 1'b1) begin
         bad++;
         $display("FAIL seq8_cap2 done got=%b exp=1", done1);
      end
   endtask

   task automatic test_partial5();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      wq0.delete(); wq1.delete();
      do_start();
      send_img(0, -1, 1'b1);
      finish_load("partial5");
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         img.delete();
         for (int i = 0; i < int'($urandom_range(17, 1)); i++)
            img.push_back(8'($urandom));
         wq0.delete(); wq1.delete();
         do_start();
         send_img(0, -1, 1'b1);
         finish_load("random");
      end
   endtask

   task automatic test_overflow();
      img.delete();
      for (int i = 0; i < 9; i++) img.push_back(8'($urandom));
      wq0.delete(); wq1.delete();
      do_start();
      send_img(0, -1, 1'b1);
      total++;
      if ({err1, ready1, crst1, done1, busy1} !== 5'b10000) begin
         bad++;
         $display("FAIL overflow err/ready/crst/done/busy got=%b exp=10000",
                  {err1, ready1, crst1, done1, busy1});
      end
      repeat (3) @(negedge clk);
      total++;
      if (crst1 !== 1'b0) begin
         bad++;
         $display("FAIL overflow_hold core_rst_n got=%b exp=0", crst1);
      end
      check_image("overflow", 1);
   endtask

   task automatic test_reset_mid();
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
      wq0.delete(); wq1.delete();
      do_start();
      send_img(0, -1, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("reset_mid");
      total++;
      if (wq0.size() != 1 || wq0[0] !== wr_t'{12'd0, {img[3], img[2], img[1], img[0]}, 4'hF}) begin
         bad++;
         $display("FAIL reset_mid writes got=%0d exp=1", wq0.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
      wq0.delete(); wq1.delete();
      do_start();
      send_img(0, -1, 1'b1);
      finish_load("reload");
   endtask

   task automatic test_gaps_start();
      img.delete();
      for (int i = 0; i < 11; i++) img.push_back(8'($urandom));
      wq0.delete(); wq1.delete();
      do_start();
      send_img(2, 5, 1'b1);
      finish_load("gaps_start");
   endtask

   task automatic test_start_with_valid();
      wq0.delete(); wq1.delete();
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h99;
      byte_last  = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      img.delete();
      for (int i = 0; i < 6; i++) img.push_back(8'($urandom_range(255, 1)) ^ 8'h99 | 8'h01);
      send_img(0, -1, 1'b1);
      finish_load("start_with_valid");
   endtask

   initial begin
      test_reset();
      test_seq8();
      test_partial5();
      test_random();
      test_overflow();
      test_reset_mid();
      test_gaps_start();
      test_start_with_valid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
